// File: rtl/jtpinpon_rom_slot.sv
// Single-entry ROM word cache between a video layer and the SDRAM arbiter.
// A miss on the client address issues one SDRAM read. The returned word is
// kept with its tag, and rom_ok flags a hit on the current address.
module jtpinpon_rom_slot #(
  parameter int unsigned           AW     = 12,
  parameter int unsigned           DW     = 16,
  parameter int unsigned           SAW    = 22,
  parameter logic [SAW-1:0]        OFFSET = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [DW-1:0]  rom_data,
  output logic           rom_ok,
  output logic           sdram_req,
  output logic [SAW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           sdram_dst,
  input  logic [DW-1:0]  sdram_din
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  data_q,  data_d;
  logic [AW-1:0]  tag_q,   tag_d;
  logic [AW-1:0]  pend_q,  pend_d;
  logic           valid_q, valid_d;
  logic           req_q,   req_d;
  logic [SAW-1:0] saddr_q, saddr_d;

  logic hit;

  // Tag match against the live client address; rom_ok follows it combinationally.
  assign hit        = valid_q && (tag_q == rom_addr);
  assign rom_ok     = rom_cs && hit;
  assign rom_data   = data_q;
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

  // Next-state logic: issue on miss, hold request until ack, capture on dst.
  // The old tag/valid stay in place until the capture edge, so a hit on the
  // previously cached word keeps working while a fetch is in flight.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rom_cs && !hit) begin
          pend_d  = rom_addr;
          saddr_d = OFFSET + SAW'(rom_addr);
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
          if (sdram_dst) begin
            data_d  = sdram_din;
            tag_d   = pend_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (sdram_dst) begin
          data_d  = sdram_din;
          tag_d   = pend_q;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and cache registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      tag_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
    end
  end

endmodule

// File: tb/tb_jtpinpon_rom_slot.sv
// Bench for jtpinpon_rom_slot: directed scenarios followed by random traffic,
// all outputs compared against a transaction-level cache model.
module tb_jtpinpon_rom_slot;

  localparam int unsigned MASK = 32'h3F_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_cs;
  logic [11:0] rom_addr;
  logic        sdram_ack, sdram_dst;
  logic [15:0] sdram_din;

  logic [15:0] rom_data,  rom_data_b;
  logic        rom_ok,    rom_ok_b;
  logic        sdram_req, sdram_req_b;
  logic [21:0] sdram_addr, sdram_addr_b;

  int n_checks = 0;
  int n_err    = 0;

  // Model: single cached word plus at most one outstanding transfer.
  bit          m_valid, m_busy, m_acked;
  bit [11:0]   m_tag, m_pend;
  bit [15:0]   m_data;
  int unsigned m_ea, m_eb;

  jtpinpon_rom_slot #(.AW(12), .DW(16), .SAW(22), .OFFSET(22'h01_0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
    .sdram_din(sdram_din)
  );

  jtpinpon_rom_slot #(.AW(12), .DW(16), .SAW(22), .OFFSET(22'h3F_FFF0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data_b), .rom_ok(rom_ok_b), .sdram_req(sdram_req_b),
    .sdram_addr(sdram_addr_b), .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
    .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_acked = 0;
    m_tag = '0; m_pend = '0; m_data = '0;
    m_ea = 0; m_eb = 0;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_update();
    if (!m_busy) begin
      if (rom_cs && !(m_valid && m_tag == rom_addr)) begin
        m_busy  = 1;
        m_acked = 0;
        m_pend  = rom_addr;
        m_ea    = (32'h01_0000 + 32'(rom_addr)) & MASK;
        m_eb    = (32'h3F_FFF0 + 32'(rom_addr)) & MASK;
      end
    end else begin
      if (!m_acked && sdram_ack) m_acked = 1;
      if (m_acked && sdram_dst) begin
        m_valid = 1;
        m_tag   = m_pend;
        m_data  = sdram_din;
        m_busy  = 0;
        m_acked = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit exp_ok, exp_req;
    exp_ok  = rom_cs && m_valid && (m_tag == rom_addr);
    exp_req = m_busy && !m_acked;
    check("rom_ok",          32'(rom_ok),       32'(exp_ok));
    check("rom_data",        32'(rom_data),     32'(m_data));
    check("sdram_req",       32'(sdram_req),    32'(exp_req));
    check("sdram_addr",      32'(sdram_addr),   m_ea);
    check("sdram_req_wrap",  32'(sdram_req_b),  32'(exp_req));
    check("sdram_addr_wrap", 32'(sdram_addr_b), m_eb);
  endtask

  task automatic step(input logic cs, input logic [11:0] a, input logic ack,
                      input logic dst, input logic [15:0] din);
    @(negedge clk);
    rom_cs = cs; rom_addr = a; sdram_ack = ack; sdram_dst = dst; sdram_din = din;
    #1 compare_all();
    @(posedge clk);
    model_update();
  endtask

  // Miss on a, ack after na idle request cycles, dst nd cycles after ack
  // (nd=0: coincident), client address a2 after the ack.
  task automatic serve(input logic [11:0] a, input logic [11:0] a2, input int na,
                       input int nd, input logic [15:0] d);
    step(1'b1, a, 1'b0, 1'b0, '0);
    repeat (na) step(1'b1, a, 1'b0, 1'b0, '0);
    if (nd == 0) step(1'b1, a, 1'b1, 1'b1, d);
    else begin
      step(1'b1, a, 1'b1, 1'b0, '0);
      repeat (nd - 1) step(1'b1, a2, 1'b0, 1'b0, '0);
      step(1'b1, a2, 1'b0, 1'b1, d);
    end
  endtask

  initial begin
    logic [11:0] pool [6];
    logic [11:0] ra;
    logic        rcs, rack, rdst;
    pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h123;
    pool[3] = 12'hFFF; pool[4] = 12'h020; pool[5] = 12'h800;

    rst_n = 1'b0; rom_cs = 1'b0; rom_addr = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_din = '0;
    model_reset();
    #3 compare_all();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // First miss and fill
    step(1'b1, 12'h123, 1'b0, 1'b0, '0);
    #1 check("first_req", 32'(sdram_req), 32'd1);
    check("first_addr", 32'(sdram_addr), 32'h01_0123);
    repeat (2) step(1'b1, 12'h123, 1'b0, 1'b0, '0);
    step(1'b1, 12'h123, 1'b1, 1'b0, '0);
    step(1'b1, 12'h123, 1'b0, 1'b0, '0);
    step(1'b1, 12'h123, 1'b0, 1'b1, 16'hBEEF);
    #1 check("fill_data", 32'(rom_data), 32'hBEEF);
    check("fill_ok", 32'(rom_ok), 32'd1);
    repeat (3) step(1'b1, 12'h123, 1'b0, 1'b0, '0);

    // Hit then miss, then back to the first address
    serve(12'h124, 12'h124, 1, 1, 16'h0124);
    serve(12'h123, 12'h123, 0, 3, 16'hC0DE);
    #1 check("refill_ok", 32'(rom_ok), 32'd1);
    check("refill_data", 32'(rom_data), 32'hC0DE);

    // Address change mid-flight
    serve(12'h010, 12'h020, 1, 2, 16'h1111);
    #1 check("midflight_ok", 32'(rom_ok), 32'd0);
    step(1'b1, 12'h020, 1'b0, 1'b0, '0);
    #1 check("second_req", 32'(sdram_req), 32'd1);
    check("second_addr", 32'(sdram_addr), 32'h01_0020);
    check("wrap_addr", 32'(sdram_addr_b), 32'h00_0010);

    // Coincident ack and dst
    step(1'b1, 12'h020, 1'b1, 1'b1, 16'hA5A5);
    #1 check("coinc_data", 32'(rom_data), 32'hA5A5);
    check("coinc_ok", 32'(rom_ok), 32'd1);
    check("coinc_req", 32'(sdram_req), 32'd0);
    step(1'b1, 12'h020, 1'b0, 1'b0, '0);

    // Reset while waiting for data, stray dst right after release
    step(1'b1, 12'h055, 1'b0, 1'b0, '0);
    step(1'b1, 12'h055, 1'b1, 1'b0, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("rst_ok", 32'(rom_ok), 32'd0);
    check("rst_data", 32'(rom_data), 32'd0);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    @(negedge clk);
    rom_cs = 1'b1; rom_addr = 12'h055; sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_din = 16'h7777;
    #2 rst_n = 1'b1;
    #1 compare_all();
    @(posedge clk);
    model_update();
    #1 check("post_rst_ok", 32'(rom_ok), 32'd0);
    check("post_rst_req", 32'(sdram_req), 32'd1);
    check("post_rst_addr", 32'(sdram_addr), 32'h01_0055);

    // Random traffic; the arbiter side follows the model's view of the request
    ra = 12'h055;
    for (int i = 0; i < 2000; i++) begin
      rcs = ($urandom_range(7) != 0);
      if ($urandom_range(3) == 0) ra = pool[$urandom_range(5)];
      if (m_busy) begin
        rack = !m_acked && ($urandom_range(2) == 0);
        rdst = (m_acked || rack) && ($urandom_range(2) == 0);
      end else begin
        rack = ($urandom_range(4) == 0);
        rdst = ($urandom_range(4) == 0);
      end
      step(rcs, ra, rack, rdst, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
